// File: rtl/spi_slave_burst.sv
// SPI slave with burst support, running entirely in the system clock domain.
// sclk/ss/mosi are oversampled through a synchroniser chain. Each frame becomes
// single-cycle register-bus write strobes or read-request strobes.
module spi_slave_burst #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err,
  output logic              busy
);

  localparam int MAX_BITS = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int CNT_W    = (MAX_BITS > 2) ? $clog2(MAX_BITS) : 1;

  localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_INC  = (AUTO_INC != 0) ? ADDR_W'(1) : '0;
  localparam logic              SCLK_IDLE = (CPOL != 0);
  localparam logic              SAMPLE_ON_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA_WR,
    DATA_RD
  } state_e;

  // Synchroniser chains and edge-detector history
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, vld_q;
  logic                   sclk_prev_q, ss_prev_q, armed_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sample_edge, shift_edge, ss_fall, ss_rise;

  // FSM and datapath registers
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      hdr_q, hdr_d;
  logic [DATA_W-1:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   first_q, first_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   err_q, err_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Oversample the SPI pins; armed_q blocks frames already in progress at reset release
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & ss_s);
    end
  end

  // Edge classification on the synchronised pins
  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    if (sclk_s != sclk_prev_q) begin
      sample_edge = (sclk_s == SAMPLE_ON_RISE);
      shift_edge  = (sclk_s != SAMPLE_ON_RISE);
    end
    ss_fall = armed_q & ss_prev_q & ~ss_s;
    ss_rise = ~ss_prev_q & ss_s;
  end

  // State and datapath register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      first_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: frame decode, strobes, address stepping and tx shifting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    first_d = first_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = 1'b0;

    // Write address steps on the clk after the strobe, so reg_we sees the old address
    if (we_q) begin
      addr_d = addr_q + ADDR_INC;
    end

    // Read data arrives the clk after reg_re; the next shift edge only clears first_q
    if (re_q) begin
      tx_d    = reg_rdata;
      first_d = 1'b1;
    end else if (shift_edge && (state_q == DATA_RD)) begin
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ss_fall) begin
          state_d = HDR;
        end
      end
      default: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = (cnt_q != '0);
        end else if (sample_edge) begin
          case (state_q)
            HDR: begin
              if (cnt_q == HDR_LAST) begin
                cnt_d  = '0;
                addr_d = {hdr_q[ADDR_W-2:0], mosi_s};
                if (hdr_q[ADDR_W-1]) begin
                  state_d = DATA_RD;
                  re_d    = 1'b1;
                end else begin
                  state_d = DATA_WR;
                end
              end else begin
                cnt_d = cnt_q + CNT_ONE;
                hdr_d = {hdr_q[ADDR_W-2:0], mosi_s};
              end
            end
            DATA_WR: begin
              if (cnt_q == DATA_LAST) begin
                cnt_d   = '0;
                we_d    = 1'b1;
                wdata_d = {rx_q[DATA_W-2:0], mosi_s};
              end else begin
                cnt_d = cnt_q + CNT_ONE;
                rx_d  = {rx_q[DATA_W-2:0], mosi_s};
              end
            end
            DATA_RD: begin
              if (cnt_q == DATA_LAST) begin
                cnt_d  = '0;
                addr_d = addr_q + ADDR_INC;
                re_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
    endcase
  end

  assign miso_oe   = (state_q == DATA_RD) & ~ss_s;
  assign miso      = miso_oe & tx_q[DATA_W-1];
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: three instances (mode0 auto-inc, mode3,
// mode0 fixed address) driven by bit-level SPI master tasks and checked against
// a transaction-level model of expected strobes and miso bytes.
module tb_spi_slave_burst;

  localparam int H = 80;  // sclk half period = 8 clk periods

  typedef struct packed {
    logic [1:0] k;
    logic [6:0] a;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_v [3];
  logic       ss_v   [3];
  logic       mosi_v [3];
  logic       miso_v [3];
  logic       oe_v   [3];
  logic [6:0] addr_v [3];
  logic [7:0] wdata_v[3];
  logic       we_v   [3];
  logic       re_v   [3];
  logic [7:0] rdata_v[3];
  logic       err_v  [3];
  logic       busy_v [3];

  int         checks = 0;
  int         errors = 0;
  int         we_cnt [3] = '{0, 0, 0};
  int         err_seen[3] = '{0, 0, 0};
  int         exp_err[3] = '{0, 0, 0};
  logic       rd_active[3] = '{1'b0, 1'b0, 1'b0};
  logic [6:0] last_wa;
  logic [7:0] last_wd;

  ev_t        exp_wr[$];
  ev_t        exp_re[$];
  bit         fbits[$];
  bit         mbits[$];
  logic [7:0] tx_words[4];

  always #5 clk = ~clk;

  spi_slave_burst #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2), .CPOL(0), .CPHA(0), .AUTO_INC(1)) u_m0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .reg_addr(addr_v[0]), .reg_wdata(wdata_v[0]),
    .reg_we(we_v[0]), .reg_re(re_v[0]), .reg_rdata(rdata_v[0]), .frame_err(err_v[0]),
    .busy(busy_v[0]));

  spi_slave_burst #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2), .CPOL(1), .CPHA(1), .AUTO_INC(1)) u_m3 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .reg_addr(addr_v[1]), .reg_wdata(wdata_v[1]),
    .reg_we(we_v[1]), .reg_re(re_v[1]), .reg_rdata(rdata_v[1]), .frame_err(err_v[1]),
    .busy(busy_v[1]));

  spi_slave_burst #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2), .CPOL(0), .CPHA(0), .AUTO_INC(0)) u_fix (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]), .ss(ss_v[2]), .mosi(mosi_v[2]),
    .miso(miso_v[2]), .miso_oe(oe_v[2]), .reg_addr(addr_v[2]), .reg_wdata(wdata_v[2]),
    .reg_we(we_v[2]), .reg_re(re_v[2]), .reg_rdata(rdata_v[2]), .frame_err(err_v[2]),
    .busy(busy_v[2]));

  // Register-file model: read data is the address xor 0x5A
  function automatic logic [7:0] model_rdata(input logic [6:0] a);
    return {1'b0, a} ^ 8'h5A;
  endfunction

  assign rdata_v[0] = model_rdata(addr_v[0]);
  assign rdata_v[1] = model_rdata(addr_v[1]);
  assign rdata_v[2] = model_rdata(addr_v[2]);

  function automatic logic [6:0] addr_at(input logic [6:0] base, input int i, input bit inc);
    return inc ? 7'(int'(base) + i) : base;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input logic rw, input logic [6:0] addr, input int nwords);
    logic [7:0] w;
    fbits.delete();
    fbits.push_back(rw);
    for (int i = 6; i >= 0; i--) fbits.push_back(addr[i]);
    for (int n = 0; n < nwords; n++) begin
      w = tx_words[n];
      for (int b = 7; b >= 0; b--) fbits.push_back(w[b]);
    end
  endtask

  task automatic expect_write(input int k, input logic [6:0] addr, input int nwords, input bit inc);
    for (int i = 0; i < nwords; i++)
      exp_wr.push_back('{k: 2'(k), a: addr_at(addr, i, inc), d: tx_words[i]});
  endtask

  // One read request after the header, then one more after every complete word
  task automatic expect_read(input int k, input logic [6:0] addr, input int nwords);
    for (int i = 0; i <= nwords; i++)
      exp_re.push_back('{k: 2'(k), a: addr_at(addr, i, 1'b1), d: 8'h00});
  endtask

  task automatic ss_low(input int k);
    mbits.delete();
    ss_v[k] = 1'b0;
    #(H);
  endtask

  task automatic send_bits(input int k, input logic cpol, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      if (cpol) sclk_v[k] = 1'b0;
      mosi_v[k] = fbits[i];
      #(H);
      mbits.push_back(miso_v[k]);
      sclk_v[k] = 1'b1;
      #(H);
      if (!cpol) sclk_v[k] = 1'b0;
    end
  endtask

  task automatic ss_high(input int k);
    #(H);
    ss_v[k]   = 1'b1;
    mosi_v[k] = 1'b0;
    #(4 * H);
  endtask

  task automatic run_frame(input int k, input logic cpol, input int nbits);
    ss_low(k);
    send_bits(k, cpol, 0, nbits);
    ss_high(k);
  endtask

  function automatic logic [7:0] miso_byte(input int w);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mbits[8 + 8*w + i];
    return b;
  endfunction

  // Per-cycle compare of strobes against the expected-transaction queues
  always @(negedge clk) begin
    ev_t e;
    for (int k = 0; k < 3; k++) begin
      if (we_v[k] === 1'b1) begin
        we_cnt[k]++;
        if (k == 0) begin
          last_wa = addr_v[k];
          last_wd = wdata_v[k];
        end
        if (exp_wr.size() == 0) begin
          chk("we_unexpected", {k[7:0], 1'b0, addr_v[k], wdata_v[k]}, 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          chk("we_inst", k, {30'd0, e.k});
          chk("we_addr", {25'd0, addr_v[k]}, {25'd0, e.a});
          chk("we_data", {24'd0, wdata_v[k]}, {24'd0, e.d});
        end
      end
      if (re_v[k] === 1'b1) begin
        if (exp_re.size() == 0) begin
          chk("re_unexpected", {k[7:0], 1'b0, addr_v[k]}, 32'hFFFF_FFFF);
        end else begin
          e = exp_re.pop_front();
          chk("re_inst", k, {30'd0, e.k});
          chk("re_addr", {25'd0, addr_v[k]}, {25'd0, e.a});
        end
      end
      if (err_v[k] === 1'b1) err_seen[k]++;
      chk("miso_pad", {30'd0, oe_v[k] & ~rd_active[k], ~oe_v[k] & miso_v[k]}, 32'd0);
    end
  end

  initial begin
    int we0, err0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ss_v[k]   = 1'b1;
      mosi_v[k] = 1'b0;
      sclk_v[k] = (k == 1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_outs", {11'd0, miso_v[k], oe_v[k], addr_v[k], wdata_v[k], we_v[k], re_v[k],
                         err_v[k], busy_v[k]}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // T1: mode0 single write
    tx_words[0] = 8'h15;
    build(1'b0, 7'h2A, 1);
    expect_write(0, 7'h2A, 1, 1'b1);
    run_frame(0, 1'b0, 16);
    chk("t1_we_count", we_cnt[0], 1);
    chk("t1_addr", {25'd0, last_wa}, 32'h2A);
    chk("t1_data", {24'd0, last_wd}, 32'h15);

    // T2: mode0 read burst with address wrap
    for (int i = 0; i < 4; i++) tx_words[i] = 8'h00;
    build(1'b1, 7'h7F, 3);
    expect_read(0, 7'h7F, 3);
    rd_active[0] = 1'b1;
    run_frame(0, 1'b0, 32);
    rd_active[0] = 1'b0;
    chk("t2_miso0", {24'd0, miso_byte(0)}, 32'h25);
    chk("t2_miso1", {24'd0, miso_byte(1)}, 32'h5A);
    chk("t2_miso2", {24'd0, miso_byte(2)}, 32'h5B);
    for (int w = 0; w < 3; w++)
      chk("t2_miso_model", {24'd0, miso_byte(w)}, {24'd0, model_rdata(addr_at(7'h7F, w, 1'b1))});

    // T3: mode3 write burst
    tx_words[0] = 8'hA5;
    tx_words[1] = 8'h3C;
    build(1'b0, 7'h10, 2);
    expect_write(1, 7'h10, 2, 1'b1);
    run_frame(1, 1'b1, 24);
    chk("t3_we_count", we_cnt[1], 2);

    // T4: abort after 11 bits
    we0 = we_cnt[0];
    tx_words[0] = 8'hFF;
    build(1'b0, 7'h2A, 1);
    exp_err[0]++;
    ss_low(0);
    send_bits(0, 1'b0, 0, 11);
    #(H);
    chk("t4_busy_mid", {31'd0, busy_v[0]}, 32'd1);
    ss_v[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_busy_after", {31'd0, busy_v[0]}, 32'd0);
    #(4 * H);
    chk("t4_err_count", err_seen[0], 1);
    chk("t4_no_we", we_cnt[0], we0);

    // T5: reset mid-frame, frame remainder ignored, next frame works
    we0  = we_cnt[0];
    err0 = err_seen[0];
    tx_words[0] = 8'hC3;
    build(1'b0, 7'h33, 1);
    ss_low(0);
    send_bits(0, 1'b0, 0, 5);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_bits(0, 1'b0, 5, 16);
    chk("t5_busy_ignored", {31'd0, busy_v[0]}, 32'd0);
    ss_high(0);
    chk("t5_no_we", we_cnt[0], we0);
    chk("t5_no_err", err_seen[0], err0);
    tx_words[0] = 8'h0F;
    build(1'b0, 7'h33, 1);
    expect_write(0, 7'h33, 1, 1'b1);
    run_frame(0, 1'b0, 16);
    chk("t5_we_after", we_cnt[0], we0 + 1);
    chk("t5_data", {24'd0, last_wd}, 32'h0F);

    // T6: fixed-address write burst
    tx_words[0] = 8'h11;
    tx_words[1] = 8'h22;
    build(1'b0, 7'h05, 2);
    expect_write(2, 7'h05, 2, 1'b0);
    run_frame(2, 1'b0, 24);
    chk("t6_we_count", we_cnt[2], 2);

    repeat (20) @(posedge clk);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("re_queue_drained", exp_re.size(), 0);
    for (int k = 0; k < 3; k++) chk("frame_err_total", err_seen[k], exp_err[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
